// File: rtl/aes_key_sched_ctrl_if.sv
// Key-schedule controller bus: key intake, generator drive/return and round-key read port.
interface aes_key_sched_ctrl_if;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         abort;
  logic         kg_start;
  logic [3:0]   kg_rc;
  logic [127:0] kg_key;
  logic         kg_finished;
  logic [127:0] kg_keyout;
  logic         keys_valid;
  logic         busy;
  logic         err;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         rk_rd_err;

  modport slave (
    input  key_valid, key_in, abort, kg_finished, kg_keyout, rk_rd_en, rk_rd_idx,
    output key_ready, kg_start, kg_rc, kg_key, keys_valid, busy, err, rk_rd_data, rk_rd_err
  );

  modport master (
    output key_valid, key_in, abort, kg_finished, kg_keyout, rk_rd_en, rk_rd_idx,
    input  key_ready, kg_start, kg_rc, kg_key, keys_valid, busy, err, rk_rd_data, rk_rd_err
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 round-key sequencer: drives the KeyGeneration core through rounds 0..9,
// banks the 11 round keys and serves them through a registered read port.
module aes_key_sched_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_key_sched_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;
  localparam int         NKEYS    = 11;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [1:0]             state_q, state_d;
  logic [127:0]           cur_q, cur_d;
  logic [3:0]             rc_q, rc_d, kg_rc_q;
  logic [7:0]             wait_q, wait_d;
  logic                   kv_q, kv_d;
  logic                   err_q, err_d;
  logic [NKEYS-1:0][127:0] rk_q;
  logic                   rk_we;
  logic [3:0]             rk_widx;
  logic [127:0]           rk_wdata;
  logic [127:0]           rd_data_q, rd_word;
  logic                   rd_err_q, rd_hit;
  logic                   in_expand;

  assign in_expand = (state_q == S_EXPAND);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rc_d     = rc_q;
    wait_d   = wait_q;
    kv_d     = kv_q;
    err_d    = err_q;
    rk_we    = 1'b0;
    rk_widx  = 4'd0;
    rk_wdata = '0;
    if (in_expand) begin
      // abort wins over a same-cycle finish
      if (bus.abort) begin
        state_d = S_IDLE;
      end else if (bus.kg_finished) begin
        rk_we    = 1'b1;
        rk_widx  = rc_q + 4'd1;
        rk_wdata = bus.kg_keyout;
        cur_d    = bus.kg_keyout;
        rc_d     = rc_q + 4'd1;
        wait_d   = 8'd0;
        if (rc_q == 4'd9) begin
          state_d = S_DONE;
          kv_d    = 1'b1;
        end
      end else if (wait_q == WAIT_LAST) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end else if (bus.key_valid) begin
      state_d  = S_EXPAND;
      cur_d    = bus.key_in;
      rc_d     = 4'd0;
      wait_d   = 8'd0;
      kv_d     = 1'b0;
      err_d    = 1'b0;
      rk_we    = 1'b1;
      rk_widx  = 4'd0;
      rk_wdata = bus.key_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rc_q    <= 4'd0;
      kg_rc_q <= 4'd0;
      wait_q  <= 8'd0;
      kv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rc_q    <= rc_d;
      wait_q  <= wait_d;
      kv_q    <= kv_d;
      err_q   <= err_d;
      // kg_rc tracks rc only while expanding so it holds the last round afterwards
      if (state_d == S_EXPAND) kg_rc_q <= rc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_q <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++)
        if (rk_we && rk_widx == 4'(i)) rk_q[i] <= rk_wdata;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NKEYS; i++)
      if (bus.rk_rd_idx == 4'(i)) rd_word = rk_q[i];
  end

  assign rd_hit = kv_q && (bus.rk_rd_idx <= 4'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else if (bus.rk_rd_en) begin
      rd_data_q <= rd_hit ? rd_word : '0;
      rd_err_q  <= !rd_hit;
    end
  end

  assign bus.key_ready  = !in_expand;
  assign bus.busy       = in_expand;
  assign bus.kg_start   = in_expand;
  assign bus.kg_rc      = kg_rc_q;
  assign bus.kg_key     = cur_q;
  assign bus.keys_valid = kv_q;
  assign bus.err        = err_q;
  assign bus.rk_rd_data = rd_data_q;
  assign bus.rk_rd_err  = rd_err_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: arithmetic AES-128 key-expansion model plus a stallable generator.
module tb_aes_key_sched_ctrl;
  localparam int WMAX = 15;
  localparam logic [127:0] FIPS_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0, errors = 0;
  int stall_round = -1, stall_len = 0, hang_round = -1, rwait = 0;

  aes_key_sched_ctrl_if bus();
  aes_key_sched_ctrl #(.WAIT_MAX(WMAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (v^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    s = inv;
    for (int r = 1; r <= 4; r++) s ^= (inv << r) | (inv >> (8 - r));
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 0; i < int'(r); i++) c = xt(c);
    return c;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    t = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])} ^ {rcon(r), 24'h0};
    w[0] ^= t; w[1] ^= w[0]; w[2] ^= w[1]; w[3] ^= w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [10:0][127:0] expand(input logic [127:0] k);
    logic [10:0][127:0] ks;
    ks[0] = k;
    for (int r = 0; r < 10; r++) ks[r+1] = next_key(ks[r], 4'(r));
    return ks;
  endfunction

  // Generator: answers in the start cycle unless told to stall or hang on a round
  assign bus.kg_finished = bus.kg_start && (int'(bus.kg_rc) != hang_round) &&
                           !(int'(bus.kg_rc) == stall_round && rwait < stall_len);
  assign bus.kg_keyout   = next_key(bus.kg_key, bus.kg_rc);
  always @(posedge clk) rwait <= (bus.kg_start && !bus.kg_finished) ? rwait + 1 : 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {127'd0, obs}, {127'd0, exp});
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  task automatic accept(input logic [127:0] k);
    bus.key_valid = 1'b1; bus.key_in = k;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] i, output logic [127:0] d, output logic e);
    bus.rk_rd_en = 1'b1; bus.rk_rd_idx = i;
    step();
    bus.rk_rd_en = 1'b0;
    d = bus.rk_rd_data; e = bus.rk_rd_err;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!bus.keys_valid && !bus.err && n < max) begin
      step(); n++;
    end
  endtask

  // Back-to-back reads of the whole bank starting at a random index
  task automatic chk_bank(input string tag, input logic [10:0][127:0] ek);
    logic [127:0] d; logic e; int off, idx;
    off = $urandom_range(10);
    for (int i = 0; i < 11; i++) begin
      idx = (i + off) % 11;
      rd(4'(idx), d, e);
      chk($sformatf("%s_rk%0d", tag, idx), d, ek[idx]);
      chkb($sformatf("%s_rkerr%0d", tag, idx), e, 1'b0);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k, d;
    logic e;
    int n, c4;
    rst_n = 1'b0;
    bus.key_valid = 1'b0; bus.key_in = '0; bus.abort = 1'b0;
    bus.rk_rd_en = 1'b0; bus.rk_rd_idx = 4'd0;
    repeat (2) step();
    chkb("rst_ready", bus.key_ready, 1'b1);
    chkb("rst_start", bus.kg_start, 1'b0);
    chk ("rst_rc", {124'd0, bus.kg_rc}, 128'd0);
    chk ("rst_key", bus.kg_key, 128'd0);
    chkb("rst_kv", bus.keys_valid, 1'b0);
    chkb("rst_busy", bus.busy, 1'b0);
    chkb("rst_err", bus.err, 1'b0);
    chk ("rst_rdata", bus.rk_rd_data, 128'd0);
    chkb("rst_rerr", bus.rk_rd_err, 1'b0);
    rst_n = 1'b1;
    step();

    // FIPS-197 key, ideal generator
    accept(FIPS_K);
    chkb("exp_busy", bus.busy, 1'b1);
    chkb("exp_ready", bus.key_ready, 1'b0);
    chkb("exp_start", bus.kg_start, 1'b1);
    chk ("exp_kgkey", bus.kg_key, FIPS_K);
    chk ("exp_kgrc", {124'd0, bus.kg_rc}, 128'd0);
    wait_done(40, n);
    chki("lat_ideal", n + 1, 11);
    chkb("done_kv", bus.keys_valid, 1'b1);
    chkb("done_busy", bus.busy, 1'b0);
    chk ("done_rc_hold", {124'd0, bus.kg_rc}, 128'd9);
    rd(4'd10, d, e);
    chk ("fips_rk10", d, FIPS_RA);
    rd(4'd1, d, e);
    chk ("fips_rk1", d, FIPS_R1);
    chk_bank("fips", expand(FIPS_K));
    rd(4'd11, d, e);
    chk ("rd11_data", d, 128'd0);
    chkb("rd11_err", e, 1'b1);
    rd(4'd15, d, e);
    chk ("rd15_data", d, 128'd0);
    chkb("rd15_err", e, 1'b1);

    // 3-cycle stall in round 4, rekey from DONE
    stall_round = 4; stall_len = 3;
    accept(FIPS_K);
    chkb("rekey_kv_drop", bus.keys_valid, 1'b0);
    n = 0; c4 = 0;
    while (!bus.keys_valid && n < 40) begin
      if (bus.busy && bus.kg_rc == 4'd4) c4++;
      step(); n++;
    end
    chki("lat_stall", n + 1, 14);
    chki("rc4_stall_cycles", c4, 4);
    chk_bank("stall", expand(FIPS_K));
    stall_round = -1;

    // Generator hangs in round 2
    hang_round = 2;
    k = rand128();
    accept(k);
    wait_done(60, n);
    chki("to_lat", n, 17);
    chkb("to_err", bus.err, 1'b1);
    chkb("to_busy", bus.busy, 1'b0);
    chkb("to_kv", bus.keys_valid, 1'b0);
    chkb("to_ready", bus.key_ready, 1'b1);
    chkb("to_start", bus.kg_start, 1'b0);
    hang_round = -1;
    k = rand128();
    accept(k);
    chkb("err_clear", bus.err, 1'b0);
    wait_done(40, n);
    chki("lat_after_err", n + 1, 11);
    chk_bank("after_err", expand(k));

    // Abort at the 5th EXPAND cycle
    accept(rand128());
    repeat (4) step();
    chkb("abort_pre_busy", bus.busy, 1'b1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chkb("abort_busy", bus.busy, 1'b0);
    chkb("abort_ready", bus.key_ready, 1'b1);
    chkb("abort_kv", bus.keys_valid, 1'b0);
    chkb("abort_start", bus.kg_start, 1'b0);
    rd(4'd0, d, e);
    chk ("abort_rd_data", d, 128'd0);
    chkb("abort_rd_err", e, 1'b1);

    // Random keys with random single-round stalls and a read during expansion
    for (int it = 0; it < 3; it++) begin
      stall_round = int'($urandom_range(9));
      stall_len   = int'($urandom_range(4));
      k = rand128();
      accept(k);
      rd(4'($urandom_range(10)), d, e);
      chk ($sformatf("rnd%0d_exp_rd_data", it), d, 128'd0);
      chkb($sformatf("rnd%0d_exp_rd_err", it), e, 1'b1);
      wait_done(60, n);
      chki($sformatf("rnd%0d_lat", it), n + 2, 11 + stall_len);
      chk_bank($sformatf("rnd%0d", it), expand(k));
    end

    // Asynchronous reset mid-round 6
    stall_round = 6; stall_len = 3;
    accept(FIPS_K);
    n = 0;
    while (bus.kg_rc != 4'd6 && n < 40) begin
      step(); n++;
    end
    chk ("reach_rc6", {124'd0, bus.kg_rc}, 128'd6);
    step();
    #2 rst_n = 1'b0;
    #1;
    chkb("arst_busy", bus.busy, 1'b0);
    chkb("arst_start", bus.kg_start, 1'b0);
    chk ("arst_rc", {124'd0, bus.kg_rc}, 128'd0);
    chk ("arst_key", bus.kg_key, 128'd0);
    chkb("arst_ready", bus.key_ready, 1'b1);
    chkb("arst_kv", bus.keys_valid, 1'b0);
    chkb("arst_err", bus.err, 1'b0);
    chk ("arst_rdata", bus.rk_rd_data, 128'd0);
    chkb("arst_rerr", bus.rk_rd_err, 1'b0);
    step();
    rst_n = 1'b1;
    stall_round = -1;
    step();
    k = rand128();
    accept(k);
    wait_done(40, n);
    chki("lat_post_rst", n + 1, 11);
    chk_bank("post_rst", expand(k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
